// File: rtl/registro_solicitudes.sv
// Request register and door timer for the elevator controller: synchronises call buttons,
// latches requests into s, and holds esperar while the door is open. Option: REABRIR_PUERTA_EN.
module registro_solicitudes #(
  parameter int T_PUERTA    = 50,
  parameter int SYNC_ETAPAS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] botones,
  input  logic [3:0] estado,
  output logic [9:0] s,
  output logic       esperar
);

  localparam int CW = $clog2(T_PUERTA + 1);
  localparam logic [CW-1:0] CNT_INI = CW'(T_PUERTA - 1);

  typedef enum logic {CERRADA, ABIERTA} puerta_t;

  puerta_t estado_act, estado_sig;

  logic [SYNC_ETAPAS-1:0][9:0] sync_q;
  logic [9:0]    btn_q;
  logic [9:0]    flanco;
  logic [3:0]    est_q;
  logic          mov_q;
  logic          llegada;
  logic          arranque;
  logic [9:0]    servido;
  logic          reabrir;
  logic          limpiar;
  logic [CW-1:0] cnt;

  // NOTE: every flop, synchroniser stages included, uses <= so all stages sample the same old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      btn_q  <= '0;
      est_q  <= '0;
      mov_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_ETAPAS-2:0], botones};
      btn_q  <= sync_q[SYNC_ETAPAS-1];
      est_q  <= estado;
      mov_q  <= est_q[3];
    end
  end

  assign flanco   = sync_q[SYNC_ETAPAS-1] & ~btn_q;
  assign llegada  = mov_q & ~est_q[3];
  assign arranque = est_q[3] & ~mov_q;

  // Requests the car satisfies at its current floor, given its direction.
  // NOTE: default assignment first so no path through the case leaves servido unassigned (no latch).
  always_comb begin
    servido = '0;
    case (est_q[1:0])
      2'd0: servido = 10'h041;
      2'd1: servido = est_q[2] ? 10'h084 : 10'h082;
      2'd2: servido = est_q[2] ? 10'h110 : 10'h108;
      default: servido = 10'h220;
    endcase
  end

`ifdef REABRIR_PUERTA_EN
  assign reabrir = (estado_act == ABIERTA) && (|(flanco & servido));
`else
  assign reabrir = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_act <= CERRADA;
    else        estado_act <= estado_sig;
  end

  always_comb begin
    estado_sig = estado_act;
    case (estado_act)
      CERRADA: begin
        if (llegada || (!est_q[3] && |(s & servido))) estado_sig = ABIERTA;
      end
      ABIERTA: begin
        if (arranque)                      estado_sig = CERRADA;
        else if (cnt == '0 && !reabrir)    estado_sig = CERRADA;
      end
      default: estado_sig = CERRADA;
    endcase
  end

  // A car that starts moving with the door open stops the clearing immediately.
  always_comb begin
    esperar = (estado_act == ABIERTA);
    limpiar = (estado_act == ABIERTA) ? !arranque : (estado_sig == ABIERTA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((estado_act == CERRADA && estado_sig == ABIERTA) || reabrir) begin
      cnt <= CNT_INI;
    end else if (estado_act == ABIERTA && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Clear beats a same-cycle set on the same bit; other bits still latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= '0;
    else        s <= (s | flanco) & ~(limpiar ? servido : 10'h000);
  end

endmodule

// File: tb/tb_registro_solicitudes.sv
// Self-checking bench for registro_solicitudes: vector table for served sets plus
// hand-written sequences, all checked through a cycle-stamped scoreboard.
module tb_registro_solicitudes;

  localparam int T  = 50;
  localparam int SE = 2;
`ifdef REABRIR_PUERTA_EN
  localparam int HOLD_REABRE = 2 * T - 3;
`else
  localparam int HOLD_REABRE = T;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] botones;
  logic [3:0] estado;
  logic [9:0] s;
  logic       esperar;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    string      name;
    logic [10:0] exp;
  } esperado_t;

  typedef struct {
    logic [3:0] parada;
    logic [9:0] exp_s;
  } vector_t;

  esperado_t sb[$];
  vector_t   tabla[8];

  registro_solicitudes #(.T_PUERTA(T), .SYNC_ETAPAS(SE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .botones (botones),
    .estado  (estado),
    .s       (s),
    .esperar (esperar)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got esperar=%0b s=%h, expected esperar=%0b s=%h",
               name, got[10], got[9:0], exp[10], exp[9:0]);
    end
  endtask

  task automatic expect_at(input int delta, input string name, input logic esp, input logic [9:0] sv);
    esperado_t e;
    e.due  = cyc + delta;
    e.name = name;
    e.exp  = {esp, sv};
    sb.push_back(e);
  endtask

  // Scoreboard drain: compare entries due on this cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, {esperar, s}, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] est);
    estado  = est;
    botones = '0;
    rst_n   = 1'b0;
    tick(2);
    rst_n   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tabla[0] = '{4'b0000, 10'h3BE};
    tabla[1] = '{4'b0100, 10'h3BE};
    tabla[2] = '{4'b0101, 10'h37B};
    tabla[3] = '{4'b0001, 10'h37D};
    tabla[4] = '{4'b0110, 10'h2EF};
    tabla[5] = '{4'b0010, 10'h2F7};
    tabla[6] = '{4'b0011, 10'h1DF};
    tabla[7] = '{4'b0111, 10'h1DF};

    // Reset with every button held, then release with buttons still held.
    rst_n   = 1'b0;
    botones = '1;
    estado  = 4'b1000;
    tick(2);
    check("reset_state", {esperar, s}, 11'h000);
    tick(1);
    check("reset_state_held", {esperar, s}, 11'h000);
    rst_n = 1'b1;
    expect_at(SE, "rst_release_pre", 1'b0, 10'h000);
    expect_at(SE + 1, "rst_release_set", 1'b0, 10'h3FF);
    tick(5);
    botones = '0;
    tick(2);

    // Single-cycle press while moving, then latency check.
    do_reset(4'b1101);
    tick(3);
    botones[8] = 1'b1;
    expect_at(SE, "press8_pre", 1'b0, 10'h000);
    expect_at(SE + 1, "press8_set", 1'b0, 10'h100);
    tick(1);
    botones[8] = 1'b0;
    tick(4);

    // Arrival at floor 3 going up with bits 2,3,4,8 pending; bit 8 stays held throughout.
    do_reset(4'b1110);
    botones = 10'b0100011100;
    tick(1);
    botones = 10'h100;
    tick(4);
    expect_at(0, "multi_set", 1'b0, 10'h11C);
    estado = 4'b0110;
    expect_at(1, "arr3_pre", 1'b0, 10'h11C);
    expect_at(2, "arr3_open", 1'b1, 10'h00C);
    expect_at(T + 1, "arr3_last", 1'b1, 10'h00C);
    expect_at(T + 2, "arr3_close", 1'b0, 10'h00C);
    tick(T + 6);
    expect_at(0, "held8_once", 1'b0, 10'h00C);
    tick(1);
    botones = '0;

    // Served-set table: all requests pending, arrive, check what survives.
    for (int i = 0; i < 8; i++) begin
      do_reset({1'b1, tabla[i].parada[2:0]});
      botones = '1;
      tick(4);
      botones = '0;
      tick(2);
      expect_at(0, $sformatf("tbl%0d_full", i), 1'b0, 10'h3FF);
      estado = tabla[i].parada;
      expect_at(1, $sformatf("tbl%0d_pre", i), 1'b0, 10'h3FF);
      expect_at(2, $sformatf("tbl%0d_open", i), 1'b1, tabla[i].exp_s);
      expect_at(T + 1, $sformatf("tbl%0d_last", i), 1'b1, tabla[i].exp_s);
      expect_at(T + 2, $sformatf("tbl%0d_close", i), 1'b0, tabla[i].exp_s);
      tick(T + 4);
    end

    // Idle at floor 1: a press opens the door directly.
    do_reset(4'b0000);
    tick(2);
    botones[0] = 1'b1;
    expect_at(SE + 1, "idle_set", 1'b0, 10'h001);
    expect_at(SE + 2, "idle_open", 1'b1, 10'h000);
    expect_at(T + SE + 1, "idle_last", 1'b1, 10'h000);
    expect_at(T + SE + 2, "idle_close", 1'b0, 10'h000);
    tick(1);
    botones = '0;
    tick(T + 6);

    // Idle at floor 4, then press the cabin button while cnt is 3.
    do_reset(4'b0011);
    tick(2);
    botones[5] = 1'b1;
    tick(1);
    botones[5] = 1'b0;
    tick(47);
    botones[9] = 1'b1;
    expect_at(HOLD_REABRE - 45, "reopen_last", 1'b1, 10'h000);
    expect_at(HOLD_REABRE - 44, "reopen_close", 1'b0, 10'h000);
    tick(2);
    botones = '0;
    tick(HOLD_REABRE);

    // Floor 2 down: cabin 7 (served) and cabin 9 (not served) rise on the opening edge.
    do_reset(4'b1001);
    tick(3);
    botones = 10'h280;
    tick(1);
    estado = 4'b0001;
    expect_at(1, "conflict_pre", 1'b0, 10'h000);
    expect_at(2, "conflict_open", 1'b1, 10'h200);
    tick(1);
    botones = '0;
    tick(5);

    // Car starts moving with the door open: door drops, requests retained.
    estado = 4'b1001;
    expect_at(1, "violation_pre", 1'b1, 10'h200);
    expect_at(2, "violation_close", 1'b0, 10'h200);
    expect_at(3, "violation_stay", 1'b0, 10'h200);
    tick(5);

    check("scoreboard_drained", 11'(sb.size()), 11'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/registro_solicitudes.md
# registro_solicitudes

Request register and door timer feeding the elevator control algorithm. Synchronises the ten raw call buttons, latches each press into the request vector `s[9:0]`, and clears requests once the car serves them. Holds `esperar` high while the door is open. Consumes the algorithm's 4-bit state; produces `s` and `esperar` for it.

## Interface
- `T_PUERTA`, default 50: door-open hold time in `clk` cycles; legal range ≥1.
- `SYNC_ETAPAS`, default 2: synchroniser depth per button; legal range ≥2.

- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `botones` input 10: raw asynchronous buttons, active-high.
  - Bit map: [0] floor 1 call up, [1] floor 2 call down, [2] floor 2 call up, [3] floor 3 call down, [4] floor 3 call up, [5] floor 4 call down, [9:6] cabin buttons for floors 1–4.
- `estado` input 4: car state. [3] moving (1) / stopped (0); [2] direction, up=1; [1:0] floor index 0–3.
- `s` output 10: latched requests, same bit map as `botones`; registered.
- `esperar` output 1: door open; the car must not move. Registered.

## Operation
- **Button capture:** each `botones` bit passes through `SYNC_ETAPAS` flops. A rising edge on the synchronised value sets the matching `s` bit. A held button sets its bit once only.
- **Served set for floor f with direction d:**
  - Always the cabin bit of f.
  - Floor 1: bit 0. Floor 4: bit 5.
  - Floors 2–3: the hall bit in direction d only (up → 2/4, down → 1/3).
- **Door FSM, two states:**
  - CERRADA: `esperar`=0.
  - ABIERTA: `esperar`=1; down-counter `cnt` of width clog2(`T_PUERTA`+1).
- **CERRADA → ABIERTA** when either holds:
  - Arrival: registered `estado[3]` was 1 and is now 0.
  - Idle press: `estado[3]`=0 and any served-set bit of the current floor is set in `s`.
  - On entry: load `cnt`=`T_PUERTA`−1 and clear the served set.
- **In ABIERTA:**
  - Decrement `cnt` each cycle.
  - Served-set bits for the current floor are held at 0; new presses for them are discarded.
  - At `cnt`==0 with no reload, go to CERRADA.
- **Simultaneous set and clear on one bit:** clear wins. Sets on all other bits proceed in the same cycle.
- **`estado[3]` rising while ABIERTA** (protocol violation): force CERRADA and stop clearing. `s` is retained.
- **Reset mid-operation:** everything returns to reset values. Pending requests are lost.

## Timing
- **Reset values:**
  - `s`=10'b0, `esperar`=0, FSM=CERRADA, `cnt`=0.
  - All synchroniser flops 0; registered `estado[3]`=0.
- **Press to `s`:** a press stable before posedge k sets `s` at posedge k+`SYNC_ETAPAS`.
- **Arrival to door open:** `estado[3]` falls before posedge k; `esperar`=1 and served bits 0 after posedge k+1.
- **Door hold:** `esperar` stays high exactly `T_PUERTA` cycles, then drops at the next posedge.
- **Handshake with the algorithm:** it may move only when it samples `esperar`=0. The first cycle `esperar` is low, `s` already excludes the served bits.

## Configuration
- Macro `REABRIR_PUERTA_EN`.
- **Defined:** in ABIERTA, a synchronised rising edge on any served-set bit of the current floor reloads `cnt`=`T_PUERTA`−1, extending the hold. The bit stays cleared.
- **Undefined:** such presses are only discarded; `cnt` is unaffected.

## Test plan
- Reset: assert `rst_n`=0 with all `botones` high → `s`=0 and `esperar`=0 during reset. Release reset with buttons still held → `s`=10'h3FF after `SYNC_ETAPAS` cycles.
- Press `botones[8]` for 1 cycle while `estado`=4'b1101 → `s[8]`=1 exactly 2 cycles later. Holding the button 20 cycles sets it once.
- `s`=10'b0100011100 (bits 2, 3, 4, 8), `estado` 4'b1110 → 4'b0110 (arrive floor 3, up) → `s` becomes 10'b0000001100 (bits 2, 3 kept). `esperar`=1 for exactly 50 cycles.
- Idle at floor 1 (`estado`=4'b0000), press `botones[0]` → `esperar` rises, `s[0]` clears, door closes after `T_PUERTA`.
- With `REABRIR_PUERTA_EN`: press the cabin button of the current floor at `cnt`=3 → `esperar` lasts a further 50 cycles. Without the macro, the door closes on schedule.
- Same-cycle conflict: press `botones[7]` on the cycle the door opens at floor 2 (bit 7 is floor 2's cabin button) → `s[7]` stays 0.
- Same-cycle independent set: press `botones[9]` on that same cycle → `s[9]`=1.
